// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI controller.
package jstk_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, FINISH} state_t;

    localparam int         NUM_BYTES = 5;
    localparam logic [7:0] FILL_BYTE = 8'h00;
    localparam int         DOUT_W    = 40;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jstk_spi_byte.sv
// 8-bit SPI mode-0 shifter: the start edge is the first SCLK rise, done flags the 8th fall.
import jstk_pkg::*;

module jstk_spi_byte #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sh;
    logic             half_end;

    assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign done     = active && sclk && half_end && (bit_cnt == 3'd7);
    assign mosi     = tx_sh[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx      <= '0;
        end else if (start) begin
            // The controller already spent the low half before bit 0, so rise now.
            active  <= 1'b1;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= tx;
            rx      <= {rx[6:0], miso};
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (sclk) begin
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        active <= 1'b0;
                end else begin
                    rx <= {rx[6:0], miso};
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/jstk_spi_ctrl.sv
// PmodJSTK transaction sequencer: 5 SPI bytes per SNDREC rising edge.
// Optional decoded XPOS/YPOS/BTN outputs when JSTK_DECODE_EN is defined.
import jstk_pkg::*;

module jstk_spi_ctrl #(
    parameter int CLK_DIV  = 50,
    parameter int SS_SETUP = 1500,
    parameter int BYTE_GAP = 1000,
    parameter int SS_HOLD  = 50
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SNDREC,
    input  logic [7:0]        DIN,
    input  logic              MISO,
    output logic              SS,
    output logic              SCLK,
    output logic              MOSI,
    output logic              BUSY,
    output logic              DONE,
    output logic [DOUT_W-1:0] DOUT
`ifdef JSTK_DECODE_EN
    ,
    output logic [9:0]        XPOS,
    output logic [9:0]        YPOS,
    output logic [2:0]        BTN
`endif
);

    localparam int CNT_W = $clog2(max3(SS_SETUP, BYTE_GAP, SS_HOLD) + 1);

    state_t             state, state_nx;
    logic               prev;
    logic               edge_det;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         byte_cnt;
    logic [7:0]         din_q;
    logic [7:0]         tx_byte;
    logic [DOUT_W-1:0]  dout_next;
    logic               start_byte;
    logic               byte_done;
    logic               byte_mosi;
    logic [7:0]         rx_byte;

    assign edge_det = SNDREC && !prev;
    assign tx_byte  = (byte_cnt == 3'd0) ? din_q : FILL_BYTE;

    jstk_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk   (CLK),
        .rst   (RST),
        .start (start_byte),
        .tx    (tx_byte),
        .miso  (MISO),
        .sclk  (SCLK),
        .mosi  (byte_mosi),
        .done  (byte_done),
        .rx    (rx_byte)
    );

    always_comb begin
        state_nx   = state;
        start_byte = 1'b0;
        case (state)
            IDLE:   if (edge_det) state_nx = SETUP;
            SETUP:  if (cnt == CNT_W'(SS_SETUP - 1)) begin
                        state_nx   = SHIFT;
                        start_byte = 1'b1;
                    end
            SHIFT:  if (byte_done)
                        state_nx = (byte_cnt == 3'(NUM_BYTES - 1)) ? HOLD : GAP;
            GAP:    if (cnt == CNT_W'(BYTE_GAP - 1)) begin
                        state_nx   = SHIFT;
                        start_byte = 1'b1;
                    end
            HOLD:   if (cnt == CNT_W'(SS_HOLD - 1)) state_nx = FINISH;
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        SS   = !(state inside {SETUP, SHIFT, GAP, HOLD});
        BUSY = (state != IDLE);
        DONE = (state == FINISH);
        MOSI = 1'b0;
        if (state inside {SETUP, GAP})
            MOSI = tx_byte[7];
        else if (state == SHIFT)
            MOSI = byte_mosi;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            prev      <= 1'b0;
            cnt       <= '0;
            byte_cnt  <= '0;
            din_q     <= '0;
            dout_next <= '0;
            DOUT      <= '0;
`ifdef JSTK_DECODE_EN
            XPOS      <= '0;
            YPOS      <= '0;
            BTN       <= '0;
`endif
        end else begin
            prev  <= SNDREC;
            state <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (state inside {SETUP, GAP, HOLD})
                cnt <= cnt + CNT_W'(1);
            if (state == IDLE && edge_det) begin
                din_q    <= DIN;
                byte_cnt <= '0;
            end
            if (byte_done) begin
                byte_cnt  <= byte_cnt + 3'd1;
                dout_next <= {dout_next[DOUT_W-9:0], rx_byte};
            end
            // DOUT only moves on a completed transaction, together with DONE.
            if (state == HOLD && state_nx == FINISH) begin
                DOUT <= dout_next;
`ifdef JSTK_DECODE_EN
                XPOS <= {dout_next[25:24], dout_next[39:32]};
                YPOS <= {dout_next[9:8], dout_next[23:16]};
                BTN  <= dout_next[2:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// Directed bench for jstk_spi_ctrl with a mode-0 slave model and a DOUT scoreboard.
module tb_jstk_spi_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SNDREC = 1'b0;
    logic [7:0]  DIN = 8'h00;
    logic        MISO;
    logic        SS, SCLK, MOSI, BUSY, DONE;
    logic [39:0] DOUT;
`ifdef JSTK_DECODE_EN
    logic [9:0]  XPOS, YPOS;
    logic [2:0]  BTN;
`endif

    jstk_spi_ctrl #(.CLK_DIV(4), .SS_SETUP(20), .BYTE_GAP(10), .SS_HOLD(5)) dut (
        .CLK(CLK), .RST(RST), .SNDREC(SNDREC), .DIN(DIN), .MISO(MISO),
        .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT)
`ifdef JSTK_DECODE_EN
        , .XPOS(XPOS), .YPOS(YPOS), .BTN(BTN)
`endif
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    logic [39:0] exp_q[$];
    logic [39:0] last_dout = '0;

    // Slave model and link monitor, sampled on the falling CLK edge.
    logic [39:0] slave_data = '0;
    logic [39:0] mosi_word;
    int pulses = 0, cyc = 0, last_rise = 0, last_fall = -1, setup_cyc = -1;
    int per_min, per_max, gap_min, gap_max, slv_idx = 0, done_cnt = 0;
    logic prev_ss = 1'b1, prev_sclk = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            MISO = 1'b0;
        end else begin
            if (prev_ss && !SS) begin
                pulses = 0; mosi_word = '0; cyc = 0; last_fall = -1; setup_cyc = -1;
                per_min = 999; per_max = 0; gap_min = 999; gap_max = 0;
                slv_idx = 0; MISO = slave_data[39];
            end else begin
                cyc++;
            end
            if (!prev_sclk && SCLK) begin
                pulses++;
                mosi_word = {mosi_word[38:0], MOSI};
                if (pulses == 1) setup_cyc = cyc;
                else if (pulses % 8 == 1) begin
                    if (cyc - last_fall < gap_min) gap_min = cyc - last_fall;
                    if (cyc - last_fall > gap_max) gap_max = cyc - last_fall;
                end else begin
                    if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                    if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                end
                last_rise = cyc;
            end
            if (prev_sclk && !SCLK) begin
                last_fall = cyc;
                slv_idx++;
                if (slv_idx < 40) MISO = slave_data[39 - slv_idx];
            end
            if (DONE) done_cnt++;
        end
        prev_ss   = SS;
        prev_sclk = SCLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic start_txn(input logic [7:0] din, input logic [39:0] data);
        DIN = din;
        slave_data = data;
        exp_q.push_back(data);
        SNDREC = 1'b1;
        tick(1);
    endtask

    task automatic wait_done(input string tag);
        logic [39:0] e;
        bit got = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (DONE) begin got = 1; break; end
        end
        if (!got) begin
            chk({tag, "_done_seen"}, DONE, 1);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_dout"}, DOUT, e);
            chk({tag, "_busy_in_done"}, BUSY, 1);
`ifdef JSTK_DECODE_EN
            chk({tag, "_xpos"}, XPOS, {e[25:24], e[39:32]});
            chk({tag, "_ypos"}, YPOS, {e[9:8], e[23:16]});
            chk({tag, "_btn"}, BTN, e[2:0]);
`endif
            last_dout = e;
            tick(1);
            chk({tag, "_done_pulse"}, DONE, 0);
            chk({tag, "_busy_drop"}, BUSY, 0);
        end
    endtask

    initial begin
        int d0;
        // Reset release
        RST = 1'b1; SNDREC = 1'b0;
        tick(3);
        RST = 1'b0;
        tick(1);
        chk("rst_ss", SS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_dout", DOUT, 0);

        // Basic transfer with timing
        d0 = done_cnt;
        start_txn(8'h81, 40'hA5023C0107);
        chk("start_busy", BUSY, 1);
        chk("start_ss", SS, 0);
        wait_done("basic");
        chk("basic_pulses", pulses, 40);
        chk("basic_mosi", mosi_word, {8'h81, 32'h0});
        chk("basic_per_min", per_min, 8);
        chk("basic_per_max", per_max, 8);
        chk("basic_setup", setup_cyc, 20);
        chk("basic_gap_min", gap_min, 10);
        chk("basic_gap_max", gap_max, 10);
        chk("basic_ss_idle", SS, 1);
        chk("basic_done_cnt", done_cnt - d0, 1);
        SNDREC = 1'b0;
        tick(5);

        // Retrigger while busy
        d0 = done_cnt;
        start_txn(8'h5A, 40'h1122334455);
        tick(50); SNDREC = 1'b0;
        tick(50); SNDREC = 1'b1;
        tick(50); SNDREC = 1'b0;
        tick(50); SNDREC = 1'b1;
        tick(50); SNDREC = 1'b0;
        wait_done("retrig");
        chk("retrig_mosi", mosi_word, {8'h5A, 32'h0});
        tick(30);
        chk("retrig_one_done", done_cnt - d0, 1);
        chk("retrig_idle", BUSY, 0);
        start_txn(8'hC3, 40'hFFEEDDCCBB);
        wait_done("retrig_next");
        chk("retrig_next_mosi", mosi_word, {8'hC3, 32'h0});
        SNDREC = 1'b0;
        tick(5);

        // Abort during byte 2
        d0 = done_cnt;
        start_txn(8'h3C, 40'h0102030405);
        for (int i = 0; i < 500 && pulses < 20; i++) tick(1);
        chk("abort_reached", pulses >= 20, 1);
        chk("abort_dout_stable", DOUT, last_dout);
        RST = 1'b1;
        tick(1);
        chk("abort_ss", SS, 1);
        chk("abort_sclk", SCLK, 0);
        chk("abort_dout", DOUT, 0);
        chk("abort_busy", BUSY, 0);
        void'(exp_q.pop_back());
        last_dout = '0;
        SNDREC = 1'b0;
        RST = 1'b0;
        tick(400);
        chk("abort_no_done", done_cnt - d0, 0);
        start_txn(8'h18, 40'hDEADBEEF42);
        wait_done("post_abort");
        SNDREC = 1'b0;
        tick(5);

        // SNDREC already high at reset release counts as an edge
        RST = 1'b1; SNDREC = 1'b1;
        tick(2);
        DIN = 8'h7E;
        slave_data = 40'h0F1E2D3C4B;
        exp_q.push_back(40'h0F1E2D3C4B);
        RST = 1'b0;
        tick(1);
        chk("rel_high_busy", BUSY, 1);
        chk("rel_high_ss", SS, 0);
        wait_done("rel_high");
        chk("rel_high_mosi", mosi_word, {8'h7E, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
